hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 5-stage MIPS core. Drives enable/clear of PC, IF/ID, ID/EX,
//  EX/MEM and MEM/WB registers, and the EX-stage forwarding muxes. Handles load-use stalls, taken-branch
//  flushes and variable-latency data-memory waits (MEM_WAIT FSM with timeout).
// PARAMETERS
//  AW          5    register address width
//  MEM_TIMEOUT 16   max MEM_WAIT cycles before mem_err; legal 2..255
// PORTS
//  clk            in   1   clock, all state on posedge
//  rst_n          in   1   reset, synchronous, active-low
//  ID_rs, ID_rt   in   AW  source regs of instruction in ID
//  EX_rs, EX_rt   in   AW  source regs of instruction in EX
//  EX_MemRead     in   1   EX instruction is a load
//  EX_wrAddr      in   AW  EX destination reg
//  EX_branch_taken in  1   branch resolved taken in EX
//  MEM_RegWrite   in   1   MEM stage writes regfile
//  MEM_wrAddr     in   AW  MEM destination reg
//  MEM_MemRead, MEM_MemWrite in 1 data-memory request in MEM
//  mem_ready      in   1   data memory completes request this cycle
//  WB_RegWrite    in   1   WB stage writes regfile
//  WB_wrAddr      in   AW  WB destination reg
//  PC_en, IF_ID_en, EX_MEM_en  out 1  register load enables
//  IF_ID_clr, ID_EX_clr, MEM_WB_clr out 1 synchronous bubble insert (RegWrite/MemWrite zeroed)
//  fwdA, fwdB     out  2   00 regfile, 10 MEM ALUOut, 01 WB result
//  mem_err        out  1   sticky: MEM_WAIT exceeded MEM_TIMEOUT
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state<=RUN, wait_cnt<=0, mem_err<=0. While rst_n=0 outputs forced:
//   PC_en=IF_ID_en=EX_MEM_en=0, all *_clr=1, fwdA=fwdB=00.
//  States: RUN, MEM_WAIT. Control outputs combinational from state + inputs (0-cycle latency).
//  mem_req = MEM_MemRead|MEM_MemWrite. mem_stall = mem_req & ~mem_ready (either state).
//  RUN: mem_stall -> next MEM_WAIT, wait_cnt<=1. MEM_WAIT: mem_ready -> RUN, wait_cnt<=0;
//   else wait_cnt++ (saturating at MEM_TIMEOUT); wait_cnt==MEM_TIMEOUT -> mem_err<=1, stay.
//   mem_err cleared only by reset. Reset mid-MEM_WAIT returns to RUN next cycle.
//  Priority (highest first):
//   1 mem_stall: PC_en=IF_ID_en=EX_MEM_en=0, ID_EX_clr=0, IF_ID_clr=0, MEM_WB_clr=1 (WB bubble);
//     branch/load-use deferred (EX held, re-evaluated on release).
//   2 EX_branch_taken: PC_en=IF_ID_en=EX_MEM_en=1, IF_ID_clr=1, ID_EX_clr=1.
//   3 load-use: EX_MemRead & EX_wrAddr!=0 & (EX_wrAddr==ID_rs | EX_wrAddr==ID_rt):
//     PC_en=IF_ID_en=0, ID_EX_clr=1, EX_MEM_en=1; exactly one bubble.
//   4 default: all enables 1, all clr 0.
//  Forwarding (independent of stall): fwdA=10 if MEM_RegWrite & MEM_wrAddr!=0 & MEM_wrAddr==EX_rs;
//   else 01 if WB_RegWrite & WB_wrAddr!=0 & WB_wrAddr==EX_rs; else 00. fwdB same with EX_rt.
//   MEM beats WB on equal addresses. Register $0 never forwarded or stalled on.
//  mem_ready with no mem_req ignored.
// CONFIGURATION
//  HAZARD_PERF_EN defined: adds output stall_cycles[31:0] and flush_count[31:0]; stall_cycles increments
//   each cycle PC_en=0 with rst_n=1, flush_count on each EX_branch_taken honoured (priority 2);
//   both wrap at 2^32, reset to 0. Undefined: ports and counters absent, identical other behaviour.
// TESTING
//  1 rst_n=0 2 cycles -> PC_en=0, all clr=1, mem_err=0; rst_n=1, no hazards -> all en=1, clr=0, fwd=00.
//  2 EX lw $5, ID add $6,$5,$1 -> 1 cycle PC_en=0,IF_ID_en=0,ID_EX_clr=1; next cycle normal; EX_wrAddr=0 -> no stall.
//  3 MEM_wrAddr=WB_wrAddr=7, both RegWrite, EX_rs=7,EX_rt=7 -> fwdA=fwdB=10; MEM_RegWrite=0 -> 01.
//  4 MEM_MemRead=1, mem_ready low 3 cycles -> state MEM_WAIT, 3 cycles frozen + MEM_WB_clr=1, release on ready.
//  5 mem_ready held 0 with MEM_TIMEOUT=4 -> mem_err=1 after 4th wait cycle, stays 1 until rst_n=0.
//  6 branch_taken with load-use same cycle -> flush only (IF_ID_clr=ID_EX_clr=1, PC_en=1); with mem_stall -> freeze.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stall/flush/forwarding decisions and a MEM_WAIT timeout FSM.
// Optional HAZARD_PERF_EN adds stall_cycles/flush_count performance counters.
module hazard_ctrl #(
    parameter int AW          = 5,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ID_rs,
    input  logic [AW-1:0] ID_rt,
    input  logic [AW-1:0] EX_rs,
    input  logic [AW-1:0] EX_rt,
    input  logic          EX_MemRead,
    input  logic [AW-1:0] EX_wrAddr,
    input  logic          EX_branch_taken,
    input  logic          MEM_RegWrite,
    input  logic [AW-1:0] MEM_wrAddr,
    input  logic          MEM_MemRead,
    input  logic          MEM_MemWrite,
    input  logic          mem_ready,
    input  logic          WB_RegWrite,
    input  logic [AW-1:0] WB_wrAddr,
    output logic          PC_en,
    output logic          IF_ID_en,
    output logic          EX_MEM_en,
    output logic          IF_ID_clr,
    output logic          ID_EX_clr,
    output logic          MEM_WB_clr,
    output logic [1:0]    fwdA,
    output logic [1:0]    fwdB,
    output logic          mem_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]   stall_cycles,
    output logic [31:0]   flush_count
`endif
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    state_t     state_q;
    logic [7:0] wait_cnt_q;
    logic       mem_err_q;

    logic mem_req;
    logic mem_stall;
    logic load_use;

    assign mem_req   = MEM_MemRead | MEM_MemWrite;
    assign mem_stall = mem_req & ~mem_ready;
    assign load_use  = EX_MemRead && (EX_wrAddr != '0) &&
                       ((EX_wrAddr == ID_rs) || (EX_wrAddr == ID_rt));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
            mem_err_q  <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_stall) begin
                        state_q    <= MEM_WAIT;
                        wait_cnt_q <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state_q    <= RUN;
                        wait_cnt_q <= 8'd0;
                    end else if (wait_cnt_q == TIMEOUT_C) begin
                        // Counter parks at the limit; error stays latched until reset.
                        mem_err_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q    <= RUN;
                    wait_cnt_q <= 8'd0;
                end
            endcase
        end
    end

    assign mem_err = mem_err_q;

    always_comb begin
        PC_en      = 1'b1;
        IF_ID_en   = 1'b1;
        EX_MEM_en  = 1'b1;
        IF_ID_clr  = 1'b0;
        ID_EX_clr  = 1'b0;
        MEM_WB_clr = 1'b0;
        if (!rst_n) begin
            PC_en      = 1'b0;
            IF_ID_en   = 1'b0;
            EX_MEM_en  = 1'b0;
            IF_ID_clr  = 1'b1;
            ID_EX_clr  = 1'b1;
            MEM_WB_clr = 1'b1;
        end else if (mem_stall) begin
            // Freeze everything up to MEM; branch/load-use re-evaluated once released.
            PC_en      = 1'b0;
            IF_ID_en   = 1'b0;
            EX_MEM_en  = 1'b0;
            MEM_WB_clr = 1'b1;
        end else if (EX_branch_taken) begin
            IF_ID_clr = 1'b1;
            ID_EX_clr = 1'b1;
        end else if (load_use) begin
            PC_en     = 1'b0;
            IF_ID_en  = 1'b0;
            ID_EX_clr = 1'b1;
        end
    end

    always_comb begin
        fwdA = 2'b00;
        fwdB = 2'b00;
        if (rst_n) begin
            if (MEM_RegWrite && (MEM_wrAddr != '0) && (MEM_wrAddr == EX_rs))
                fwdA = 2'b10;
            else if (WB_RegWrite && (WB_wrAddr != '0) && (WB_wrAddr == EX_rs))
                fwdA = 2'b01;
            if (MEM_RegWrite && (MEM_wrAddr != '0) && (MEM_wrAddr == EX_rt))
                fwdB = 2'b10;
            else if (WB_RegWrite && (WB_wrAddr != '0) && (WB_wrAddr == EX_rt))
                fwdB = 2'b01;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 32'd0;
        end else begin
            if (!PC_en)
                stall_cycles_q <= stall_cycles_q + 32'd1;
            if (EX_branch_taken && !mem_stall)
                flush_count_q <= flush_count_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule
